imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the decode stage. It accepts instructions with their PC over a valid/ready handshake and extracts the sign-extended immediate. It also reports the instruction format, computes the PC-relative target for B, J and AUIPC, and flags illegal encodings. A 2-entry skid buffer provides full throughput with a registered in_ready. It sits between the fetch queue and the register-read stage, and supports RV32I/RV64I plus Zicsr immediates.

---
 rtl/imm_gen_pipe_if.sv | 27 ++
 rtl/imm_gen_pipe.sv | 200 ++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_pipe_if.sv
// Decode-stage bundle between the fetch queue and the immediate generator:
// instruction/PC request side, decoded-immediate response side, and flush.
interface imm_gen_pipe_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [WIDTH-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_imm;
    logic [2:0]       out_fmt;
    logic [WIDTH-1:0] out_target;
    logic             out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I (+Zicsr) immediate generator: combinational decode of the
// incoming instruction, registered into an output stage backed by one skid entry.
module imm_gen_pipe #(
    parameter int WIDTH     = 32,
    parameter int EN_CSR    = 1,
    parameter int EN_TARGET = 1
) (
    input  logic         clk,
    input  logic         rst,
    imm_gen_pipe_if.slave bus
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_Z    = 3'd6;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_REG32  = 7'b0111011;

    localparam bit IS_RV64 = (WIDTH == 64);

    typedef struct packed {
        logic [WIDTH-1:0] imm;
        logic [WIDTH-1:0] target;
        logic [2:0]       fmt;
        logic             illegal;
    } entry_t;

    logic [31:0]      instr;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] imm_i;
    logic [WIDTH-1:0] imm_s;
    logic [WIDTH-1:0] imm_b;
    logic [WIDTH-1:0] imm_u;
    logic [WIDTH-1:0] imm_j;
    logic [WIDTH-1:0] imm_z;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Size casts of signed operands sign-extend, which also covers WIDTH=64 for U.
    assign imm_i = WIDTH'($signed(instr[31:20]));
    assign imm_s = WIDTH'($signed({instr[31:25], instr[11:7]}));
    assign imm_b = WIDTH'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u = WIDTH'($signed({instr[31:12], 12'b0}));
    assign imm_j = WIDTH'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
    assign imm_z = WIDTH'(instr[19:15]);

    logic [WIDTH-1:0] dec_imm;
    logic [2:0]       dec_fmt;
    logic             dec_illegal;
    logic             dec_pcrel;

    always_comb begin
        dec_imm     = '0;
        dec_fmt     = FMT_NONE;
        dec_illegal = 1'b0;
        dec_pcrel   = 1'b0;
        if (instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
        end else begin
            case (opcode)
                OP_IMM, OP_LOAD, OP_JALR: begin
                    dec_imm = imm_i;
                    dec_fmt = FMT_I;
                end
                OP_IMM32: begin
                    if (IS_RV64) begin
                        dec_imm = imm_i;
                        dec_fmt = FMT_I;
                    end else begin
                        dec_illegal = 1'b1;
                    end
                end
                OP_STORE: begin
                    dec_imm = imm_s;
                    dec_fmt = FMT_S;
                end
                OP_BRANCH: begin
                    dec_imm   = imm_b;
                    dec_fmt   = FMT_B;
                    dec_pcrel = 1'b1;
                end
                OP_LUI: begin
                    dec_imm = imm_u;
                    dec_fmt = FMT_U;
                end
                OP_AUIPC: begin
                    dec_imm   = imm_u;
                    dec_fmt   = FMT_U;
                    dec_pcrel = 1'b1;
                end
                OP_JAL: begin
                    dec_imm   = imm_j;
                    dec_fmt   = FMT_J;
                    dec_pcrel = 1'b1;
                end
                OP_SYSTEM: begin
                    if (EN_CSR != 0) begin
                        case (funct3)
                            3'b101, 3'b110, 3'b111: begin
                                dec_imm = imm_z;
                                dec_fmt = FMT_Z;
                            end
                            3'b001, 3'b010, 3'b011: begin
                                dec_imm = imm_i;
                                dec_fmt = FMT_I;
                            end
                            3'b100:  dec_illegal = 1'b1;
                            default: dec_fmt = FMT_NONE;
                        endcase
                    end
                end
                OP_REG, OP_FENCE: dec_fmt = FMT_NONE;
                OP_REG32: dec_illegal = !IS_RV64;
                default:  dec_illegal = 1'b1;
            endcase
        end
    end

    logic [WIDTH-1:0] dec_target;

    generate
        if (EN_TARGET != 0) begin : g_target
            assign dec_target = dec_pcrel ? (bus.in_pc + dec_imm) : '0;
        end else begin : g_no_target
            assign dec_target = '0;
        end
    endgenerate

    entry_t new_entry;

    assign new_entry.imm     = dec_imm;
    assign new_entry.target  = dec_target;
    assign new_entry.fmt     = dec_fmt;
    assign new_entry.illegal = dec_illegal;

    entry_t out_entry_reg;
    entry_t skid_entry_reg;
    logic   out_valid_reg;
    logic   skid_valid_reg;
    logic   accept;
    logic   drain;

    // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
    assign bus.in_ready = !skid_valid_reg;
    assign accept       = bus.in_valid && !skid_valid_reg;
    assign drain        = out_valid_reg && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            out_entry_reg  <= '0;
            skid_entry_reg <= '0;
        end else if (bus.flush) begin
            out_valid_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            // A full skid entry blocks input, so only the drain path can move data.
            if (drain) begin
                out_entry_reg  <= skid_entry_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_reg || drain) begin
                out_entry_reg <= new_entry;
                out_valid_reg <= 1'b1;
            end else begin
                skid_entry_reg <= new_entry;
                skid_valid_reg <= 1'b1;
            end
        end else if (drain) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_imm     = out_entry_reg.imm;
    assign bus.out_target  = out_entry_reg.target;
    assign bus.out_fmt     = out_entry_reg.fmt;
    assign bus.out_illegal = out_entry_reg.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: RV32 and RV64 instances driven from one directed vector
// table, with per-instance expected-response queues checked by independent monitors.
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.WIDTH(32)) b32 ();
    imm_gen_pipe_if #(.WIDTH(64)) b64 ();

    imm_gen_pipe #(.WIDTH(32), .EN_CSR(1), .EN_TARGET(1)) u32 (
        .clk (clk),
        .rst (rst),
        .bus (b32.slave)
    );

    imm_gen_pipe #(.WIDTH(64), .EN_CSR(1), .EN_TARGET(1)) u64 (
        .clk (clk),
        .rst (rst),
        .bus (b64.slave)
    );

    typedef struct {
        bit          w64;
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    vec_t q32[$];
    vec_t q64[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input bit w64, input logic [31:0] instr, input logic [63:0] pc,
                                input logic [63:0] imm, input logic [2:0] fmt,
                                input logic [63:0] tgt, input logic ill);
        vec_t v;
        v.w64 = w64; v.instr = instr; v.pc = pc;
        v.imm = imm; v.fmt = fmt; v.tgt = tgt; v.ill = ill;
        return v;
    endfunction

    // Monitors compare the presented output against the queue head every cycle it is
    // valid, so a stalled output must hold its value; the head retires on transfer.
    always @(negedge clk) begin
        if (!rst && b32.out_valid) begin
            if (q32.size() == 0) begin
                chk("u32_unexpected_output", 64'(b32.out_imm), 64'hDEAD);
            end else begin
                chk("u32_imm", 64'(b32.out_imm), 64'(q32[0].imm[31:0]));
                chk("u32_fmt", 64'(b32.out_fmt), 64'(q32[0].fmt));
                chk("u32_target", 64'(b32.out_target), 64'(q32[0].tgt[31:0]));
                chk("u32_illegal", 64'(b32.out_illegal), 64'(q32[0].ill));
                if (b32.out_ready && !b32.flush) begin
                    $display("u32 out: instr=%h imm=%h fmt=%0d tgt=%h ill=%0d",
                             q32[0].instr, b32.out_imm, b32.out_fmt, b32.out_target, b32.out_illegal);
                    void'(q32.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b64.out_valid) begin
            if (q64.size() == 0) begin
                chk("u64_unexpected_output", b64.out_imm, 64'hDEAD);
            end else begin
                chk("u64_imm", b64.out_imm, q64[0].imm);
                chk("u64_fmt", 64'(b64.out_fmt), 64'(q64[0].fmt));
                chk("u64_target", b64.out_target, q64[0].tgt);
                chk("u64_illegal", 64'(b64.out_illegal), 64'(q64[0].ill));
                if (b64.out_ready && !b64.flush) begin
                    $display("u64 out: instr=%h imm=%h fmt=%0d tgt=%h ill=%0d",
                             q64[0].instr, b64.out_imm, b64.out_fmt, b64.out_target, b64.out_illegal);
                    void'(q64.pop_front());
                end
            end
        end
    end

    task automatic drive(input int idx);
        if (vecs[idx].w64) begin
            b64.in_valid = 1'b1;
            b64.in_instr = vecs[idx].instr;
            b64.in_pc    = vecs[idx].pc;
        end else begin
            b32.in_valid = 1'b1;
            b32.in_instr = vecs[idx].instr;
            b32.in_pc    = vecs[idx].pc[31:0];
        end
    endtask

    // Offers vectors first..last back-to-back; called at posedge+1, returns at posedge+1.
    task automatic run_stream(input int first, input int last, input int max_cycles,
                              output int accepted);
        int  idx = first;
        int  cyc = 0;
        logic rdy;
        accepted = 0;
        while (idx <= last && cyc < max_cycles) begin
            drive(idx);
            @(negedge clk);
            rdy = vecs[idx].w64 ? b64.in_ready : b32.in_ready;
            if (rdy) begin
                if (vecs[idx].w64) q64.push_back(vecs[idx]);
                else               q32.push_back(vecs[idx]);
                idx++;
                accepted++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        b32.in_valid = 1'b0;
        b64.in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int cyc = 0;
        while ((q32.size() != 0 || q64.size() != 0) && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk(name, 64'(q32.size() + q64.size()), 64'd0);
    endtask

    int acc;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // RV32 directed vectors (0..12)
        vecs.push_back(mk(0, 32'hFFF00093, 64'h0,    64'hFFFFFFFF, 3'd1, 64'h0,        1'b0));
        vecs.push_back(mk(0, 32'hFE000EE3, 64'h100,  64'hFFFFFFFC, 3'd3, 64'hFC,       1'b0));
        vecs.push_back(mk(0, 32'hFE000EE3, 64'h0,    64'hFFFFFFFC, 3'd3, 64'hFFFFFFFC, 1'b0));
        vecs.push_back(mk(0, 32'h00000000, 64'h0,    64'h0,        3'd0, 64'h0,        1'b1));
        vecs.push_back(mk(0, 32'h0000001B, 64'h0,    64'h0,        3'd0, 64'h0,        1'b1));
        vecs.push_back(mk(0, 32'hFE20AC23, 64'h0,    64'hFFFFFFF8, 3'd2, 64'h0,        1'b0));
        vecs.push_back(mk(0, 32'h0010006F, 64'h1000, 64'h800,      3'd5, 64'h1800,     1'b0));
        vecs.push_back(mk(0, 32'h12345117, 64'h10,   64'h12345000, 3'd4, 64'h12345010, 1'b0));
        vecs.push_back(mk(0, 32'h002081B3, 64'h0,    64'h0,        3'd0, 64'h0,        1'b0));
        vecs.push_back(mk(0, 32'h30029073, 64'h0,    64'h300,      3'd1, 64'h0,        1'b0));
        vecs.push_back(mk(0, 32'h00000073, 64'h0,    64'h0,        3'd0, 64'h0,        1'b0));
        vecs.push_back(mk(0, 32'h00004073, 64'h0,    64'h0,        3'd0, 64'h0,        1'b1));
        vecs.push_back(mk(0, 32'h3002D073, 64'h0,    64'h5,        3'd6, 64'h0,        1'b0));
        // RV64 directed vectors (13..17)
        vecs.push_back(mk(1, 32'h800000B7, 64'h0, 64'hFFFFFFFF80000000, 3'd4, 64'h0, 1'b0));
        vecs.push_back(mk(1, 32'h3002D073, 64'h0, 64'h5,                3'd6, 64'h0, 1'b0));
        vecs.push_back(mk(1, 32'hFFF0809B, 64'h0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(1, 32'h0000003B, 64'h0, 64'h0,                3'd0, 64'h0, 1'b0));
        vecs.push_back(mk(1, 32'hFE000EE3, 64'h0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 64'hFFFFFFFFFFFFFFFC, 1'b0));
        // Backpressure stream (18..21)
        vecs.push_back(mk(0, 32'h00100093, 64'h0, 64'h1, 3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(0, 32'h00200093, 64'h0, 64'h2, 3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(0, 32'h00300093, 64'h0, 64'h3, 3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(0, 32'h00400093, 64'h0, 64'h4, 3'd1, 64'h0, 1'b0));
        // Flush scenario (22..25); 24 is always flushed
        vecs.push_back(mk(0, 32'h7FF00093, 64'h0, 64'h7FF,      3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(0, 32'h80000093, 64'h0, 64'hFFFFF800, 3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(0, 32'h00500093, 64'h0, 64'h5,        3'd1, 64'h0, 1'b0));
        vecs.push_back(mk(0, 32'h00600093, 64'h0, 64'h6,        3'd1, 64'h0, 1'b0));
        // Reset mid-stream (26..27)
        vecs.push_back(mk(0, 32'hFE000EE3, 64'h100,  64'hFFFFFFFC, 3'd3, 64'hFC,   1'b0));
        vecs.push_back(mk(0, 32'h0010006F, 64'h1000, 64'h800,      3'd5, 64'h1800, 1'b0));

        b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b1;
        b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b1;

        // Reset state
        #12;
        chk("reset_out_valid", 64'(b32.out_valid), 64'd0);
        chk("reset_in_ready", 64'(b32.in_ready), 64'd1);
        chk("reset_out_imm", 64'(b32.out_imm), 64'd0);
        chk("reset_out_fmt", 64'(b32.out_fmt), 64'd0);
        chk("reset_out_illegal", 64'(b64.out_illegal), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Single transaction latency
        run_stream(0, 0, 20, acc);
        chk("accept_v0", 64'(acc), 64'd1);
        @(negedge clk);
        chk("latency_out_valid", 64'(b32.out_valid), 64'd1);
        @(posedge clk);
        #1;

        // Full-throughput decode streams
        run_stream(1, 12, 12, acc);
        chk("throughput_rv32", 64'(acc), 64'd12);
        run_stream(13, 17, 5, acc);
        chk("throughput_rv64", 64'(acc), 64'd5);
        wait_drain("drain_decode");

        // Backpressure: out_ready low for 3 cycles
        b32.out_ready = 1'b0;
        run_stream(18, 21, 3, acc);
        chk("bp_accepts_before_stall", 64'(acc), 64'd2);
        @(negedge clk);
        chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
        @(posedge clk);
        #1;
        b32.out_ready = 1'b1;
        run_stream(20, 21, 10, acc);
        chk("bp_accepts_after_release", 64'(acc), 64'd2);
        wait_drain("drain_backpressure");

        // Flush with both entries full and input pending
        b32.out_ready = 1'b0;
        run_stream(22, 23, 2, acc);
        chk("flush_fill", 64'(acc), 64'd2);
        drive(24);
        b32.flush = 1'b1;
        @(posedge clk);
        #1;
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        q32.delete();
        @(negedge clk);
        chk("flush_out_valid", 64'(b32.out_valid), 64'd0);
        chk("flush_in_ready", 64'(b32.in_ready), 64'd1);
        // Flush with an otherwise accepted handshake: the input must be dropped
        @(posedge clk);
        #1;
        drive(24);
        b32.flush = 1'b1;
        @(posedge clk);
        #1;
        b32.flush = 1'b0;
        b32.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_drop_out_valid", 64'(b32.out_valid), 64'd0);
        @(posedge clk);
        #1;
        b32.out_ready = 1'b1;
        run_stream(25, 25, 20, acc);
        chk("post_flush_accept", 64'(acc), 64'd1);
        wait_drain("drain_flush");

        // Asynchronous reset mid-stream
        b32.out_ready = 1'b0;
        run_stream(26, 27, 2, acc);
        chk("rst_fill", 64'(acc), 64'd2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(b32.out_valid), 64'd0);
        chk("async_rst_out_imm", 64'(b32.out_imm), 64'd0);
        chk("async_rst_out_target", 64'(b32.out_target), 64'd0);
        chk("async_rst_out_fmt", 64'(b32.out_fmt), 64'd0);
        chk("async_rst_in_ready", 64'(b32.in_ready), 64'd1);
        q32.delete();
        q64.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        b32.out_ready = 1'b1;
        run_stream(0, 0, 20, acc);
        chk("post_rst_accept", 64'(acc), 64'd1);
        wait_drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
